ball_bounce_controller: RTL and testbench
=========================================

Name: ball_bounce_controller

Overview:
- Consumer end of the game controller's collision interface. Takes `collision` and `SingleHitPulse`, plus the ball bitmap's `HitEdgeCode`.
- Owns the ball's fixed-point position and velocity, updated once per frame.
- Bounces on collision, loses a life per single hit pulse, holds a stun period after each hit, and freezes at game over.
- Drives `topLeftX`/`topLeftY` to the ball bitmap/draw chain.

Parameters:
- INITIAL_X, 280, start X in pixels
- INITIAL_Y, 185, start Y in pixels
- INITIAL_X_SPEED, 40, start X speed (fixed-point units per frame)
- INITIAL_Y_SPEED, 20, start Y speed (fixed-point units per frame)
- Y_ACCEL, 1, gravity added to Y speed per frame
- MAX_Y_SPEED, 230, positive saturation limit of Y speed
- FIXED_POINT_MULTIPLIER, 64, internal position scale (power of two)
- LIVES, 3, lives at reset/restart (1..15)
- STUN_FRAMES, 15, frames frozen after a hit (1..255)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- collision  in  1  level, ball overlaps edge/box this pixel
- SingleHitPulse  in  1  one-cycle pulse, at most one per frame
- HitEdgeCode  in  4  side of ball touched: [3]=top [2]=right [1]=bottom [0]=left
- restart  in  1  one-cycle pulse, leave GAME_OVER
- topLeftX  out  11  signed pixel X
- topLeftY  out  11  signed pixel Y
- lives  out  4  remaining lives
- stunned  out  1  high in STUN
- game_over  out  1  high in GAME_OVER

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low (`clk`, `resetN`).
  - All state resets asynchronously.
- Reset values:
  - internal X = INITIAL_X*FPM, internal Y = INITIAL_Y*FPM.
  - xspeed = INITIAL_X_SPEED, yspeed = INITIAL_Y_SPEED.
  - lives = LIVES, pending flags = 0, stun counter = 0, state = RUN.
  - Outputs: topLeftX = INITIAL_X, topLeftY = INITIAL_Y, stunned = 0, game_over = 0.
- Arithmetic:
  - Internal X, Y, xspeed and yspeed are 32-bit signed.
  - topLeftX/topLeftY = internal value arithmetic-shifted right by log2(FPM), truncated to 11 bits, registered.
  - No clamping of position.
- Pending flags:
  - Four sticky bits pend[3:0]. On any cycle with collision=1, pend |= HitEdgeCode.
  - On a startOfFrame cycle, pend is cleared, then loaded with HitEdgeCode if collision=1 in that same cycle. That collision counts toward the next frame.
- State RUN, on startOfFrame (all in one cycle, new values visible the cycle after):
  - Negate xspeed if (pend[0] and xspeed<0) or (pend[2] and xspeed>0).
  - Negate yspeed if (pend[3] and yspeed<0) or (pend[1] and yspeed>0).
  - X += new xspeed; Y += new yspeed.
  - Then yspeed = min(new yspeed + Y_ACCEL, MAX_Y_SPEED).
  - The guarded negate prevents double-bouncing while still overlapping an edge.
- SingleHitPulse in RUN:
  - lives decremented.
  - If the result is 0 → GAME_OVER; else → STUN with stun counter = STUN_FRAMES.
- SingleHitPulse and startOfFrame in the same cycle: the position update for that frame is applied first, then the state changes.
- STUN:
  - Position and speeds frozen; pend is still cleared and reloaded at each startOfFrame.
  - At each startOfFrame the counter decrements; when it reaches 0 on that pulse → RUN.
  - SingleHitPulse is ignored.
  - stunned = 1.
- GAME_OVER:
  - Everything frozen; SingleHitPulse and collision are ignored; game_over = 1.
- restart (any state):
  - Reload all reset values except the async path; → RUN next cycle.
  - restart has priority over startOfFrame and SingleHitPulse in the same cycle.
- lives never underflows: it is decremented only from RUN while lives ≥ 1.

Test Plan:
- **Free flight:** reset, 3 startOfFrame pulses, no collision.
  - xspeed stays 40; yspeed 20→21→22→23.
  - internal X = 17920+120 → topLeftX 281; internal Y = 11840+63 → topLeftY 185.
- **Right bounce and no double-bounce:** collision with HitEdgeCode=4'b0100 mid-frame, then startOfFrame.
  - xspeed = -40, X decreases by 40.
  - Repeat right-edge collision next frame: xspeed stays -40.
- **Simultaneous collision and startOfFrame:** collision with code 4'b1000 in the same cycle as startOfFrame while yspeed>0.
  - No top bounce this frame.
  - Next startOfFrame: yspeed still not negated (yspeed>0, top guard).
  - With yspeed forced <0 (bottom bounce first), the top bounce applies.
- **Hit → STUN:** SingleHitPulse in RUN.
  - lives 3→2, stunned=1; position frozen for 15 startOfFrame pulses.
  - A second SingleHitPulse during STUN is ignored (lives stays 2).
  - RUN resumes on the 15th pulse.
- **GAME_OVER:** three hits, each after its stun has expired.
  - lives=0, game_over=1; further pulses keep lives=0.
  - restart → lives=3, topLeftX=280, topLeftY=185, RUN.
- **Mid-operation reset:** assert resetN=0 during STUN with pending flags set.
  - All outputs immediately return to their reset values; pend=0.

Source files
------------

// File: rtl/ball_bounce_controller.sv
// Ball motion controller: fixed-point position and velocity advanced once per frame,
// guarded edge bounces, life loss with a stun period, and a game-over freeze.
module ball_bounce_controller #(
  parameter int INITIAL_X              = 280,
  parameter int INITIAL_Y              = 185,
  parameter int INITIAL_X_SPEED        = 40,
  parameter int INITIAL_Y_SPEED        = 20,
  parameter int Y_ACCEL                = 1,
  parameter int MAX_Y_SPEED            = 230,
  parameter int FIXED_POINT_MULTIPLIER = 64,
  parameter int LIVES                  = 3,
  parameter int STUN_FRAMES            = 15
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collision,
  input  logic               SingleHitPulse,
  input  logic [3:0]         HitEdgeCode,
  input  logic               restart,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [3:0]         lives,
  output logic               stunned,
  output logic               game_over
);

  localparam int                 SHIFT     = $clog2(FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] X_RST     = 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] Y_RST     = 32'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] XS_RST    = 32'(INITIAL_X_SPEED);
  localparam logic signed [31:0] YS_RST    = 32'(INITIAL_Y_SPEED);
  localparam logic signed [31:0] YS_ACC    = 32'(Y_ACCEL);
  localparam logic signed [31:0] YS_MAX    = 32'(MAX_Y_SPEED);
  localparam logic signed [10:0] TLX_RST   = 11'(INITIAL_X);
  localparam logic signed [10:0] TLY_RST   = 11'(INITIAL_Y);
  localparam logic [3:0]         LIVES_RST = 4'(LIVES);
  localparam logic [7:0]         STUN_RST  = 8'(STUN_FRAMES);

  typedef enum logic [1:0] {S_RUN, S_STUN, S_OVER} state_t;

  state_t                state_q, state_d;
  logic signed [31:0]    x_q, x_d, y_q, y_d;
  logic signed [31:0]    xs_q, xs_d, ys_q, ys_d;
  logic signed [31:0]    xs_n, ys_n;
  logic signed [10:0]    tlx_q, tlx_d, tly_q, tly_d;
  logic [3:0]            pend_q, pend_d;
  logic [3:0]            lives_q, lives_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  hit_run;

  function automatic logic signed [31:0] sat_yspeed(input logic signed [31:0] v);
    return (v > YS_MAX) ? YS_MAX : v;
  endfunction

  function automatic logic signed [10:0] to_pixel(input logic signed [31:0] v);
    return 11'(v >>> SHIFT);
  endfunction

  assign hit_run = (state_q == S_RUN) && SingleHitPulse && (lives_q != 4'd0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= S_RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (hit_run) state_d = (lives_q == 4'd1) ? S_OVER : S_STUN;
        S_STUN:  if (startOfFrame && (cnt_q <= 8'd1)) state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    stunned   = (state_q == S_STUN);
    game_over = (state_q == S_OVER);
  end

  // Guarded negation: only reverse when moving into the touched side, so a
  // ball still overlapping the edge on the next frame does not bounce back.
  always_comb begin
    xs_n = xs_q;
    ys_n = ys_q;
    if ((pend_q[0] && (xs_q < 32'sd0)) || (pend_q[2] && (xs_q > 32'sd0))) xs_n = -xs_q;
    if ((pend_q[3] && (ys_q < 32'sd0)) || (pend_q[1] && (ys_q > 32'sd0))) ys_n = -ys_q;
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    pend_d  = pend_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    if (restart) begin
      x_d     = X_RST;
      y_d     = Y_RST;
      xs_d    = XS_RST;
      ys_d    = YS_RST;
      pend_d  = 4'd0;
      lives_d = LIVES_RST;
      cnt_d   = 8'd0;
    end else begin
      if (state_q != S_OVER) begin
        if (startOfFrame)   pend_d = collision ? HitEdgeCode : 4'd0;
        else if (collision) pend_d = pend_q | HitEdgeCode;
      end
      if ((state_q == S_RUN) && startOfFrame) begin
        xs_d = xs_n;
        x_d  = x_q + xs_n;
        y_d  = y_q + ys_n;
        ys_d = sat_yspeed(ys_n + YS_ACC);
      end
      if (hit_run) begin
        lives_d = lives_q - 4'd1;
        cnt_d   = STUN_RST;
      end
      if ((state_q == S_STUN) && startOfFrame) cnt_d = cnt_q - 8'd1;
    end
    tlx_d = to_pixel(x_d);
    tly_d = to_pixel(y_d);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q     <= X_RST;
      y_q     <= Y_RST;
      xs_q    <= XS_RST;
      ys_q    <= YS_RST;
      pend_q  <= 4'd0;
      lives_q <= LIVES_RST;
      cnt_q   <= 8'd0;
      tlx_q   <= TLX_RST;
      tly_q   <= TLY_RST;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      pend_q  <= pend_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      tlx_q   <= tlx_d;
      tly_q   <= tly_d;
    end
  end

  assign topLeftX = tlx_q;
  assign topLeftY = tly_q;
  assign lives    = lives_q;

endmodule

// File: tb/tb_ball_bounce_controller.sv
// Bench for ball_bounce_controller: directed scenarios plus random frames, with a
// behavioural ball model feeding a scoreboard that a monitor drains every cycle.
`timescale 1ns/1ps
module tb_ball_bounce_controller;
  localparam int FPM = 64, X0 = 280, Y0 = 185, XS0 = 40, YS0 = 20;
  localparam int YACC = 1, YMAX = 230, LIVES0 = 3, STUN0 = 15;

  logic        clk = 1'b0, resetN = 1'b1;
  logic        startOfFrame = 1'b0, collision = 1'b0, SingleHitPulse = 1'b0, restart = 1'b0;
  logic [3:0]  HitEdgeCode = 4'd0;
  logic [10:0] topLeftX, topLeftY;
  logic [3:0]  lives;
  logic        stunned, game_over;

  int checks = 0, errors = 0;

  typedef struct {int x; int y; int lv; int st; int go;} exp_t;
  exp_t sb[$];

  // Behavioural ball: plain integers, stunned means frames left > 0, over means no lives.
  longint m_px, m_py, m_vx, m_vy;
  int     m_lives, m_stun;
  bit     m_pend[4];

  ball_bounce_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
    .SingleHitPulse(SingleHitPulse), .HitEdgeCode(HitEdgeCode), .restart(restart),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .lives(lives),
    .stunned(stunned), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pix(input longint p);
    longint q;
    q = (p >= 0) ? p / FPM : -((-p + FPM - 1) / FPM);
    return int'(q & 64'h7FF);
  endfunction

  task automatic model_reset();
    m_px = X0 * FPM; m_py = Y0 * FPM; m_vx = XS0; m_vy = YS0;
    m_lives = LIVES0; m_stun = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_step(input bit sof, input bit col, input bit [3:0] code,
                            input bit hit, input bit rs);
    bit prev[4];
    bit over;
    if (rs) begin
      model_reset();
    end else begin
      over = (m_lives == 0);
      for (int i = 0; i < 4; i++) prev[i] = m_pend[i];
      if (!over) begin
        for (int i = 0; i < 4; i++) begin
          if (sof) m_pend[i] = col && code[i];
          else     m_pend[i] = m_pend[i] || (col && code[i]);
        end
      end
      if (!over && m_stun == 0) begin
        if (sof) begin
          if ((prev[0] && m_vx < 0) || (prev[2] && m_vx > 0)) m_vx = -m_vx;
          if ((prev[3] && m_vy < 0) || (prev[1] && m_vy > 0)) m_vy = -m_vy;
          m_px = m_px + m_vx;
          m_py = m_py + m_vy;
          m_vy = (m_vy + YACC > YMAX) ? YMAX : m_vy + YACC;
        end
        if (hit) begin
          m_lives--;
          if (m_lives > 0) m_stun = STUN0;
        end
      end else if (!over && sof) begin
        m_stun--;
      end
    end
  endtask

  task automatic cycle(input bit sof, input bit col, input bit [3:0] code,
                       input bit hit, input bit rs);
    exp_t e;
    @(negedge clk);
    startOfFrame = sof; collision = col; HitEdgeCode = code;
    SingleHitPulse = hit; restart = rs;
    model_step(sof, col, code, hit, rs);
    e.x = pix(m_px); e.y = pix(m_py); e.lv = m_lives;
    e.st = (m_stun > 0) ? 1 : 0; e.go = (m_lives == 0) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic sof();
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic hit();
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_topLeftX"}, int'(topLeftX), X0);
    cmp({tag, "_topLeftY"}, int'(topLeftY), Y0);
    cmp({tag, "_lives"}, int'(lives), LIVES0);
    cmp({tag, "_stunned"}, int'(stunned), 0);
    cmp({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("sb_topLeftX", int'(topLeftX), e.x);
        cmp("sb_topLeftY", int'(topLeftY), e.y);
        cmp("sb_lives", int'(lives), e.lv);
        cmp("sb_stunned", int'(stunned), e.st);
        cmp("sb_game_over", int'(game_over), e.go);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit hit_done;
    int len;
    model_reset();
    #1 resetN = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Free flight
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (3) begin
      sof();
      cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    cmp("flight_topLeftX", int'(topLeftX), 281);
    cmp("flight_topLeftY", int'(topLeftY), 185);

    // Right bounce, then no double bounce while still overlapping
    repeat (2) begin
      cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
      sof();
    end

    // Top collision coincident with startOfFrame, then bottom bounce, then top bounce
    cycle(1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
    sof();
    cycle(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0);
    sof();
    cycle(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
    sof();
    sof();

    // Hit into stun, ignored second hit, resume on 15th frame
    hit();
    cmp("hit1_lives", int'(lives), 2);
    cmp("hit1_stunned", int'(stunned), 1);
    for (int i = 0; i < STUN0 - 1; i++) begin
      sof();
      if (i == 5) hit();
    end
    cmp("stun_lives", int'(lives), 2);
    cmp("stun_stunned", int'(stunned), 1);
    sof();
    cmp("resume_stunned", int'(stunned), 0);

    // Run out of lives
    hit();
    repeat (STUN0) sof();
    sof();
    cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    cmp("over_lives", int'(lives), 0);
    cmp("over_game_over", int'(game_over), 1);
    hit();
    cycle(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0);
    sof();
    hit();
    cmp("over_hold_lives", int'(lives), 0);
    cycle(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    cmp("restart_topLeftX", int'(topLeftX), X0);
    cmp("restart_topLeftY", int'(topLeftY), Y0);
    cmp("restart_lives", int'(lives), LIVES0);
    cmp("restart_game_over", int'(game_over), 0);
    sof();

    // Asynchronous reset in the middle of a stun with pending flags set
    hit();
    cycle(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    #1 resetN = 1'b0;
    startOfFrame = 1'b0; collision = 1'b0; SingleHitPulse = 1'b0; restart = 1'b0;
    sb.delete();
    model_reset();
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    sof();
    sof();

    // Random frames
    for (int f = 0; f < 300; f++) begin
      len = $urandom_range(3, 8);
      hit_done = 1'b0;
      for (int c = 0; c < len; c++) begin
        bit h, r;
        h = !hit_done && ($urandom_range(0, 30) == 0);
        if (h) hit_done = 1'b1;
        r = (m_lives == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 300) == 0);
        cycle(c == 0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), h, r);
      end
    end

    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    cmp("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
